// File: rtl/pipa_moding_decoder.sv
// PIPA moding decoder: sequences PIPASW/PIPDAT phases, classifies the
// accelerometer pulse lines and accumulates signed 6-phase frame sums.
module pipa_moding_decoder (
  input  logic       SIM_CLK,
  input  logic       SIM_RST_n,
  input  logic       tick,
  input  logic       enable,
  input  logic       clr_err,
  input  logic       PIPAXp,
  input  logic       PIPAXm,
  input  logic       PIPAYp,
  input  logic       PIPAYm,
  input  logic       PIPAZp,
  input  logic       PIPAZm,
  output logic       PIPASW,
  output logic       PIPDAT,
  output logic       pinc_x,
  output logic       minc_x,
  output logic       pinc_y,
  output logic       minc_y,
  output logic       pinc_z,
  output logic       minc_z,
  output logic       frame_done,
  output logic [3:0] net_x,
  output logic [3:0] net_y,
  output logic [3:0] net_z,
  output logic       err_x,
  output logic       err_y,
  output logic       err_z,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE,
    SW,
    GAP,
    DAT,
    OUT
  } state_t;

  state_t          state_q;
  logic [1:0]      dcnt_q;
  logic [2:0]      phase_q;
  logic [2:0][3:0] acc_q;
  logic [2:0][3:0] acc_d;
  logic [2:0][3:0] net_q;
  logic [2:0]      err_q;
  logic [2:0]      err_d;
  logic [2:0]      pinc_q;
  logic [2:0]      minc_q;
  logic            sw_q;
  logic            dat_q;
  logic            fd_q;
  logic            ovr_q;
  logic            ovr_d;

  logic [2:0] p_s;
  logic [2:0] m_s;
  logic [2:0] plus_s;
  logic [2:0] minus_s;
  logic [2:0] bad_s;
  logic       sample_s;

  assign p_s     = {PIPAZp, PIPAYp, PIPAXp};
  assign m_s     = {PIPAZm, PIPAYm, PIPAXm};
  assign plus_s  = p_s & ~m_s;
  assign minus_s = ~p_s & m_s;
  assign bad_s   = ~(p_s ^ m_s);

  // The only sampling edge is the one closing the last DAT cycle.
  assign sample_s = (state_q == DAT) && (dcnt_q == 2'd3);

  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < 3; i++) begin
      unique case (1'b1)
        plus_s[i]:  acc_d[i] = acc_q[i] + 4'd1;
        minus_s[i]: acc_d[i] = acc_q[i] - 4'd1;
        default:    acc_d[i] = acc_q[i];
      endcase
    end
  end

  // New errors win over a coincident clear.
  assign err_d = (sample_s ? bad_s : 3'b000)
               | (err_q & {3{~clr_err}});
  assign ovr_d = (tick && (state_q != IDLE))
               | (ovr_q & ~clr_err);

  always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      phase_q <= '0;
      acc_q   <= '0;
      net_q   <= '0;
      err_q   <= '0;
      pinc_q  <= '0;
      minc_q  <= '0;
      sw_q    <= 1'b0;
      dat_q   <= 1'b0;
      fd_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      err_q  <= err_d;
      ovr_q  <= ovr_d;
      sw_q   <= 1'b0;
      pinc_q <= '0;
      minc_q <= '0;
      fd_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tick && enable) begin
            state_q <= SW;
            sw_q    <= 1'b1;
          end
        end
        SW: begin
          state_q <= GAP;
        end
        GAP: begin
          state_q <= DAT;
          dat_q   <= 1'b1;
          dcnt_q  <= '0;
        end
        DAT: begin
          if (sample_s) begin
            state_q <= OUT;
            dat_q   <= 1'b0;
            pinc_q  <= plus_s;
            minc_q  <= minus_s;
            if (phase_q == 3'd5) begin
              net_q   <= acc_d;
              acc_q   <= '0;
              phase_q <= '0;
              fd_q    <= 1'b1;
            end else begin
              acc_q   <= acc_d;
              phase_q <= phase_q + 3'd1;
            end
          end else begin
            dcnt_q <= dcnt_q + 2'd1;
          end
        end
        OUT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign PIPASW     = sw_q;
  assign PIPDAT     = dat_q;
  assign pinc_x     = pinc_q[0];
  assign pinc_y     = pinc_q[1];
  assign pinc_z     = pinc_q[2];
  assign minc_x     = minc_q[0];
  assign minc_y     = minc_q[1];
  assign minc_z     = minc_q[2];
  assign frame_done = fd_q;
  assign net_x      = net_q[0];
  assign net_y      = net_q[1];
  assign net_z      = net_q[2];
  assign err_x      = err_q[0];
  assign err_y      = err_q[1];
  assign err_z      = err_q[2];
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_pipa_moding_decoder.sv
// Bench for pipa_moding_decoder: phase-level model compared every
// cycle, plus literal checks of frame sums, pulse counts and flags.
module tb_pipa_moding_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic enable = 1'b0;
  logic clr_err = 1'b0;
  logic [5:0] pipa = '0;

  logic PIPASW, PIPDAT, frame_done, overrun;
  logic pinc_x, minc_x, pinc_y, minc_y, pinc_z, minc_z;
  logic [3:0] net_x, net_y, net_z;
  logic err_x, err_y, err_z;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipa_moding_decoder dut (
    .SIM_CLK(clk), .SIM_RST_n(rst_n),
    .tick(tick), .enable(enable), .clr_err(clr_err),
    .PIPAXp(pipa[0]), .PIPAXm(pipa[1]),
    .PIPAYp(pipa[2]), .PIPAYm(pipa[3]),
    .PIPAZp(pipa[4]), .PIPAZm(pipa[5]),
    .PIPASW(PIPASW), .PIPDAT(PIPDAT),
    .pinc_x(pinc_x), .minc_x(minc_x),
    .pinc_y(pinc_y), .minc_y(minc_y),
    .pinc_z(pinc_z), .minc_z(minc_z),
    .frame_done(frame_done),
    .net_x(net_x), .net_y(net_y), .net_z(net_z),
    .err_x(err_x), .err_y(err_y), .err_z(err_z),
    .overrun(overrun)
  );

  // Model: m_k is cycles since phase start (T=0), -1 when idle.
  int m_k, m_ph;
  int m_acc[3];
  int m_net[3];
  bit [2:0] m_pinc, m_minc, m_err;
  bit m_fd, m_ovr;

  always @(posedge clk or negedge rst_n) begin
    bit p, m, ne;
    if (!rst_n) begin
      m_k = -1; m_ph = 0;
      m_pinc = 0; m_minc = 0; m_err = 0;
      m_fd = 0; m_ovr = 0;
      for (int i = 0; i < 3; i++) begin
        m_acc[i] = 0; m_net[i] = 0;
      end
    end else begin
      m_pinc = 0; m_minc = 0; m_fd = 0;
      if (tick && m_k != -1) m_ovr = 1;
      else if (clr_err) m_ovr = 0;
      for (int a = 0; a < 3; a++) begin
        p = pipa[2*a]; m = pipa[2*a+1]; ne = 0;
        if (m_k == 5) begin
          if (p && !m) begin m_pinc[a] = 1; m_acc[a]++; end
          else if (!p && m) begin m_minc[a] = 1; m_acc[a]--; end
          else ne = 1;
        end
        m_err[a] = ne || (m_err[a] && !clr_err);
      end
      if (m_k == 5) begin
        if (m_ph == 5) begin
          m_fd = 1; m_ph = 0;
          for (int i = 0; i < 3; i++) begin
            m_net[i] = m_acc[i]; m_acc[i] = 0;
          end
        end else m_ph++;
      end
      if (m_k == -1) m_k = (tick && enable) ? 0 : -1;
      else if (m_k == 6) m_k = -1;
      else m_k++;
    end
  end

  function automatic logic [31:0] exp_vec();
    logic [3:0] nx, ny, nz;
    bit sw, dat;
    nx = m_net[0][3:0]; ny = m_net[1][3:0]; nz = m_net[2][3:0];
    sw = (m_k == 0);
    dat = (m_k >= 2 && m_k <= 5);
    return {7'b0, sw, dat, m_pinc, m_minc, m_fd,
            nz, ny, nx, m_err, m_ovr};
  endfunction

  function automatic logic [31:0] act_vec();
    return {7'b0, PIPASW, PIPDAT, pinc_z, pinc_y, pinc_x,
            minc_z, minc_y, minc_x, frame_done,
            net_z, net_y, net_x, err_z, err_y, err_x, overrun};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) chk("cycle_outputs", act_vec(), exp_vec());

  int n_sw, n_px, n_mx, n_py, n_my, n_fd;
  always @(negedge clk) begin
    if (PIPASW) n_sw++;
    if (pinc_x) n_px++;
    if (minc_x) n_mx++;
    if (pinc_y) n_py++;
    if (minc_y) n_my++;
    if (frame_done) n_fd++;
  end

  task automatic clr_cnt();
    n_sw = 0; n_px = 0; n_mx = 0; n_py = 0; n_my = 0; n_fd = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One phase: tick in c=0 (T = c1); valid sample in c=6 (T+5).
  task automatic phase(input logic [5:0] v, input int ovr_c,
                       input bit clr, input int len);
    for (int c = 0; c < len; c++) begin
      tick    = (c == 0) || (ovr_c != 0 && c == ovr_c);
      enable  = (c == 0);
      pipa    = (c == 6) ? v : 6'($urandom());
      clr_err = clr && (c == 6);
      step();
    end
    tick = 0; clr_err = 0;
  endtask

  task automatic pulse_clr();
    clr_err = 1; step(); clr_err = 0;
  endtask

  localparam logic [5:0] ALLP = 6'b010101;
  localparam logic [5:0] ALLM = 6'b101010;

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      tick = 1'($urandom()); enable = 1'($urandom());
      clr_err = 1'($urandom()); pipa = 6'($urandom());
      step();
    end
    chk("reset_outputs", act_vec(), 32'h0);
    tick = 0; enable = 0; clr_err = 0; pipa = 0;
    rst_n = 1; step();

    // Balanced frame
    clr_cnt();
    for (int i = 0; i < 6; i++) phase(i < 3 ? ALLP : ALLM, 0, 0, 10);
    chk("bal_sw_count", 32'(n_sw), 32'd6);
    chk("bal_pinc_x", 32'(n_px), 32'd3);
    chk("bal_minc_x", 32'(n_mx), 32'd3);
    chk("bal_frames", 32'(n_fd), 32'd1);
    chk("bal_net", {20'b0, net_z, net_y, net_x}, 32'h0);
    chk("bal_err", {29'b0, err_z, err_y, err_x}, 32'h0);

    // Acceleration frame: X plus all six phases
    clr_cnt();
    for (int i = 0; i < 6; i++) phase(i < 3 ? ALLP : 6'b101001, 0, 0, 10);
    chk("acc_net_x", 32'(net_x), 32'h6);
    chk("acc_net_yz", {24'b0, net_z, net_y}, 32'h0);
    chk("acc_pinc_x", 32'(n_px), 32'd6);

    // Illegal Y in phase 2 with coincident clear; Z missing in phase 1
    clr_cnt();
    phase(ALLP, 0, 0, 10);
    phase(6'b000101, 0, 0, 10);
    chk("ill_err_z_set", 32'(err_z), 32'h1);
    phase(6'b011101, 0, 1, 10);
    for (int i = 0; i < 3; i++) phase(ALLM, 0, 0, 10);
    chk("ill_err_y", 32'(err_y), 32'h1);
    chk("ill_err_z_clr", 32'(err_z), 32'h0);
    chk("ill_net_y", 32'(net_y), 32'hf);
    chk("ill_net_z", 32'(net_z), 32'hf);
    chk("ill_pinc_y", 32'(n_py), 32'd2);
    chk("ill_minc_y", 32'(n_my), 32'd3);
    pulse_clr();
    chk("ill_err_cleared", {29'b0, err_z, err_y, err_x}, 32'h0);

    // Tick with enable low is ignored
    clr_cnt();
    tick = 1; enable = 0; step(); tick = 0;
    repeat (10) step();
    chk("en0_sw", 32'(n_sw), 32'd0);
    chk("en0_ovr", 32'(overrun), 32'd0);

    // Overrun tick at T+3
    clr_cnt();
    phase(ALLP, 4, 0, 10);
    chk("ovr_sw", 32'(n_sw), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_pinc", 32'(n_px), 32'd1);
    pulse_clr();
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Tick in OUT is overrun; next cycle's tick is accepted
    clr_cnt();
    phase(ALLM, 7, 0, 8);
    phase(ALLM, 0, 0, 10);
    chk("out_sw", 32'(n_sw), 32'd2);
    chk("out_ovr", 32'(overrun), 32'd1);
    pulse_clr();

    // Mid-phase reset at T+4
    clr_cnt();
    tick = 1; enable = 1; pipa = ALLP; step();
    tick = 0; enable = 0;
    repeat (4) step();
    chk("mid_dat_before", 32'(PIPDAT), 32'd1);
    rst_n = 0; #1;
    chk("mid_dat_after", 32'(PIPDAT), 32'd0);
    repeat (2) step();
    rst_n = 1; step();
    chk("mid_no_inc", 32'(n_px + n_mx), 32'd0);
    for (int i = 0; i < 5; i++) phase(ALLP, 0, 0, 10);
    chk("mid_no_frame_5", 32'(n_fd), 32'd0);
    phase(ALLM, 0, 0, 10);
    chk("mid_frame_6", 32'(n_fd), 32'd1);
    chk("mid_net_x", 32'(net_x), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
